vect_mem_unit: RTL
==================

# vect_mem_unit

Vector memory stage that sits after the vector execute stage. It takes the M-lane vector operands the execute stage produces and moves them to or from a single-port, N-bit-wide data memory, one lane per cycle. A store serializes the vector into M word writes. A load issues M word reads and reassembles the returned words into one M·N vector. While an access is in flight, the unit holds the pipeline with `stall`.

## Interface

Parameters:
- `N`, 24, lane width in bits
- `M`, 6, lanes per vector
- `AW`, 16, memory word-address width

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  request valid from the EX/MEM register; sampled only in IDLE
- `memWrite`  in  1  1 = vector store, 0 = vector load; latched with `start`
- `addrBase`  in  AW  base word address, taken from lane 0 of the ALU result
- `wdata`  in  M·N  store vector (RD3 path); lane i = bits [N·i +: N]
- `memAddr`  out  AW  memory word address
- `memWe`  out  1  memory write strobe
- `memRe`  out  1  memory read strobe
- `memWdata`  out  N  memory write data
- `memRdata`  in  N  memory read data, valid exactly 1 cycle after `memRe`
- `rdata`  out  M·N  assembled load vector; lane i = bits [N·i +: N]
- `stall`  out  1  freezes upstream pipeline registers
- `done`  out  1  one-cycle completion pulse

## Operation

- States: IDLE, STORE, LOAD, DRAIN, DONE.
- IDLE:
  - When `start`=1, latch `memWrite`, `addrBase` and `wdata`.
  - Clear lane counter `i` to 0.
  - Go to STORE if `memWrite`=1, otherwise to LOAD.
- STORE:
  - Drive `memWe`=1, `memAddr`=addr, `memWdata`=latched lane i.
  - Each cycle: addr += 1, i += 1.
  - At i=M-1, go to DONE.
- LOAD:
  - Drive `memRe`=1, `memAddr`=addr.
  - Capture `memRdata` of the previous issue into shadow lane i-1 (for i>0).
  - At i=M-1, go to DRAIN.
- DRAIN:
  - No strobes.
  - Capture the final word into shadow lane M-1.
  - Go to DONE.
- DONE:
  - `done`=1.
  - If the access was a load, copy the shadow buffer into `rdata` at this edge. All lanes update together, so `rdata` is never partially updated.
  - Go to IDLE.
- `stall` = (IDLE & `start`) | STORE | LOAD | DRAIN. It is combinational, so the pipeline freezes in the same cycle the request is presented. `stall` is 0 in DONE, so the pipeline advances.
- `start` is ignored in every state except IDLE, including DONE.
- `memWe` and `memRe` are never both 1.
- Both strobes are 0 in IDLE, DRAIN and DONE.
- Address arithmetic is modulo 2^AW. The address increments wrap silently, for example 0xFFFF → 0x0000.
- `rdata` holds its value across stores and idle periods. It changes only on a load's DONE edge.
- Reset, asserted at any time including mid-access:
  - State returns to IDLE; `i`, addr, the shadow buffer and `rdata` clear to 0.
  - All outputs are 0: `memAddr`, `memWe`, `memRe`, `memWdata`, `rdata`, `stall`, `done`.
  - No further strobes are issued for the aborted access.

## Timing

- Cycle 0 is the edge at which IDLE samples `start`=1.
- Store:
  - `memWe` high on cycles 1..M.
  - `done` on cycle M+1.
  - `stall` high from the `start` cycle through cycle M.
- Load:
  - `memRe` high on cycles 1..M.
  - Data captured on cycles 2..M+1.
  - `done` and the new `rdata` on cycle M+2. `rdata` is visible during the DONE cycle.
- Minimum start-to-start spacing: M+2 cycles (store) or M+3 cycles (load).
- Outputs are registered except `stall`, which is combinational from state and `start`.

## Configuration

- `VECT_MEM_STRIDE_EN` defined:
  - Adds input port `stride` (AW bits), latched with `start`.
  - The address increments by the latched stride instead of 1, modulo 2^AW.
  - A stride of 0 is legal and repeatedly accesses `addrBase`.
- Not defined: the `stride` port is absent and the increment is fixed at 1.

## Test plan

- Store, `addrBase`=0x0010, `wdata` lanes 0..5 = 1..6:
  - `memWe` on cycles 1..6 with `memAddr` 0x10..0x15 and `memWdata` 1..6.
  - `done` on cycle 7; `stall` high on cycles 0..6.
- Load, `addrBase`=0x0020, memory model returns addr+0x100:
  - `memRe` on cycles 1..6.
  - On cycle 8, `rdata` lanes = 0x120..0x125 and `done`=1.
  - `rdata` holds through a subsequent store.
- Wrap, store at `addrBase`=0xFFFE: `memAddr` sequence is FFFE, FFFF, 0000, 0001, 0002, 0003.
- Reset mid-access:
  - Assert `rst`=0 on cycle 3 of a store: all outputs are 0 immediately, with no `memWe` after release.
  - A new load then completes normally.
- Busy protection: `start` pulsed on cycles 2 and 7 of a store → ignored, with exactly 6 writes and one `done`.
- With `VECT_MEM_STRIDE_EN`, load with `addrBase`=0x0100, `stride`=4 → read addresses 0x100, 0x104, …, 0x114.

Source files
------------

// File: rtl/vect_mem_unit.sv
// vect_mem_unit: serializes M-lane vector stores/loads onto an N-bit single-port memory, one lane per cycle.
// Optional `VECT_MEM_STRIDE_EN adds a latched address stride input.
module vect_mem_unit #(
    parameter int N  = 24,
    parameter int M  = 6,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          memWrite,
    input  logic [AW-1:0] addrBase,
`ifdef VECT_MEM_STRIDE_EN
    input  logic [AW-1:0] stride,
`endif
    input  logic [M*N-1:0] wdata,
    output logic [AW-1:0] memAddr,
    output logic          memWe,
    output logic          memRe,
    output logic [N-1:0]  memWdata,
    input  logic [N-1:0]  memRdata,
    output logic [M*N-1:0] rdata,
    output logic          stall,
    output logic          done
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [2:0] {IDLE, STORE, LOAD, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       i_q, i_d;
    logic [AW-1:0]       addr_q, addr_d, inc;
    logic [M*N-1:0]      wbuf_q, wbuf_d, rdata_q, rdata_d;
    logic [(M-1)*N-1:0]  shadow_q, shadow_d;
    logic                we_q, we_d, re_q, re_d, done_q, done_d;

`ifdef VECT_MEM_STRIDE_EN
    logic [AW-1:0] stride_q, stride_d;
    assign inc = stride_q;
`else
    assign inc = AW'(1);
`endif

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        addr_d   = addr_q;
        wbuf_d   = wbuf_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
`ifdef VECT_MEM_STRIDE_EN
        stride_d = stride_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = memWrite ? STORE : LOAD;
                i_d     = '0;
                addr_d  = addrBase;
                wbuf_d  = memWrite ? wdata : '0;
`ifdef VECT_MEM_STRIDE_EN
                stride_d = stride;
`endif
            end
            STORE: begin
                addr_d = addr_q + inc;
                i_d    = i_q + IW'(1);
                wbuf_d = wbuf_q >> N;
                if (i_q == IW'(M-1)) state_d = DONE;
            end
            LOAD: begin
                addr_d = addr_q + inc;
                i_d    = i_q + IW'(1);
                if (i_q != '0) shadow_d[N*(int'(i_q)-1) +: N] = memRdata;
                if (i_q == IW'(M-1)) state_d = DRAIN;
            end
            // final word bypasses the shadow so rdata is whole during DONE
            DRAIN: begin
                rdata_d = {memRdata, shadow_q};
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        we_d   = (state_d == STORE);
        re_d   = (state_d == LOAD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            i_q      <= '0;
            addr_q   <= '0;
            wbuf_q   <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            done_q   <= 1'b0;
`ifdef VECT_MEM_STRIDE_EN
            stride_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            addr_q   <= addr_d;
            wbuf_q   <= wbuf_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            re_q     <= re_d;
            done_q   <= done_d;
`ifdef VECT_MEM_STRIDE_EN
            stride_q <= stride_d;
`endif
        end
    end

    assign memAddr  = addr_q;
    assign memWe    = we_q;
    assign memRe    = re_q;
    assign memWdata = wbuf_q[N-1:0];
    assign rdata    = rdata_q;
    assign done     = done_q;
    assign stall    = rst & ((state_q == IDLE && start) || state_q == STORE
                           || state_q == LOAD || state_q == DRAIN);
endmodule
